// File: rtl/fque_pkg.sv
// Shared free-queue helpers: wide pointer/count types, controller states and an index
// wrap helper for circular lists whose depth need not be a power of two.
package fque_pkg;

  localparam int unsigned FqueMaxW = 16;

  typedef logic [FqueMaxW-1:0] fque_ptr_t;
  typedef logic [FqueMaxW:0]   fque_cnt_t;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } fque_state_e;

  // Advance idx by inc (inc <= depth) and wrap at depth.
  function automatic int unsigned fque_wrap_add(input int unsigned idx,
                                                input int unsigned inc,
                                                input int unsigned depth);
    int unsigned s;
    s = idx + inc;
    if (s >= depth) begin
      s = s - depth;
    end
    return s;
  endfunction

endpackage

// File: rtl/algo_mrnw_flst_grant.sv
// Ascending-index grant of up to i_avail requests out of NUMREQ.
module algo_mrnw_flst_grant
  import fque_pkg::*;
#(
  parameter int unsigned NUMREQ = 2
) (
  input  logic [NUMREQ-1:0] i_req,
  input  fque_cnt_t         i_avail,
  output logic [NUMREQ-1:0] o_gnt,
  output fque_cnt_t         o_ngnt
);

  fque_cnt_t w_cnt;

  always_comb begin
    o_gnt = '0;
    w_cnt = '0;
    for (int i = 0; i < NUMREQ; i++) begin
      if (i_req[i] && (w_cnt < i_avail)) begin
        o_gnt[i] = 1'b1;
        w_cnt    = w_cnt + 1'b1;
      end
    end
  end

  assign o_ngnt = w_cnt;

endmodule

// File: rtl/algo_mrnw_flst.sv
// Multi-read/multi-write free-pointer list: flop-based circular queue of free pointers,
// guarded by a free bitmap that rejects duplicate and out-of-range frees.
module algo_mrnw_flst
  import fque_pkg::*;
#(
  parameter int unsigned NUMPUPT  = 2,
  parameter int unsigned NUMPOPT  = 2,
  parameter int unsigned NUMADDR  = 16,
  parameter int unsigned BITADDR  = 4,
  parameter int unsigned BITQCNT  = BITADDR + 1,
  parameter int unsigned LOWMARK  = 4,
  parameter int unsigned HIGHMARK = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUMPUPT-1:0]         i_push,
  input  logic [NUMPUPT*BITADDR-1:0] i_pu_ptr,
  input  logic [NUMPOPT-1:0]         i_pop,
  output logic [NUMPOPT-1:0]         o_po_pvld,
  output logic [NUMPOPT*BITADDR-1:0] o_po_ptr,
  output logic [BITQCNT-1:0]         o_freecnt,
  output logic                       o_lowmark,
  output logic                       o_err_dup,
  output logic                       o_err_ovr,
  input  logic                       i_err_clr,
  output logic                       o_ready
);

  localparam int unsigned BITIDX = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
  typedef logic [BITIDX-1:0] idx_t;

  fque_state_e                r_state, w_state_d;
  logic [BITADDR-1:0]         r_list   [NUMADDR];
  logic [BITADDR-1:0]         w_list_d [NUMADDR];
  logic [NUMADDR-1:0]         r_bitmap, w_bitmap_d;
  idx_t                       r_head, w_head_d, r_tail, w_tail_d, r_icnt, w_icnt_d;
  logic [BITQCNT-1:0]         r_freecnt, w_freecnt_d;
  logic                       r_lowmark, w_lowmark_d;
  logic                       r_err_dup, w_err_dup_d, r_err_ovr, w_err_ovr_d;
  logic [NUMPOPT-1:0]         r_po_pvld, w_po_pvld_d;
  logic [NUMPOPT*BITADDR-1:0] r_po_ptr, w_po_ptr_d;

  logic                       w_ready;
  logic                       w_init_last;
  logic [NUMPOPT-1:0]         w_gnt;
  fque_cnt_t                  w_ngnt;
  fque_cnt_t                  w_avail;
  logic [BITADDR-1:0]         w_pu [NUMPUPT];
  logic [NUMPUPT-1:0]         w_acc, w_dup, w_ovr;
  int unsigned                w_rank;
  int unsigned                w_fc;
  idx_t                       w_idx;

  // ---------------- FSM ----------------
  assign w_init_last = (32'(r_icnt) == NUMADDR - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StInit: if (w_init_last) w_state_d = StRun;
      StRun:  w_state_d = StRun;
    endcase
  end

  always_comb begin
    w_ready = (r_state == StRun);
  end

  // ---------------- grant ----------------
  assign w_avail = fque_cnt_t'(r_freecnt);

  algo_mrnw_flst_grant #(
    .NUMREQ(NUMPOPT)
  ) u_grant (
    .i_req  (i_pop & {NUMPOPT{w_ready}}),
    .i_avail(w_avail),
    .o_gnt  (w_gnt),
    .o_ngnt (w_ngnt)
  );

  // ---------------- push screening ----------------
  always_comb begin
    for (int i = 0; i < NUMPUPT; i++) begin
      w_pu[i] = i_pu_ptr[i*BITADDR +: BITADDR];
    end
  end

  // A push is judged against the bitmap as it stood at the start of the cycle.
  always_comb begin
    w_acc = '0;
    w_dup = '0;
    w_ovr = '0;
    for (int i = 0; i < NUMPUPT; i++) begin
      if (w_ready && i_push[i]) begin
        if (32'(w_pu[i]) >= NUMADDR) begin
          w_ovr[i] = 1'b1;
        end else begin
          w_dup[i] = r_bitmap[idx_t'(w_pu[i])];
          for (int j = 0; j < i; j++) begin
            if (i_push[j] && (w_pu[j] == w_pu[i])) w_dup[i] = 1'b1;
          end
          w_acc[i] = ~w_dup[i];
        end
      end
    end
  end

  // ---------------- list, bitmap and count update ----------------
  always_comb begin
    w_list_d    = r_list;
    w_bitmap_d  = r_bitmap;
    w_head_d    = r_head;
    w_tail_d    = r_tail;
    w_icnt_d    = r_icnt;
    w_po_pvld_d = '0;
    w_po_ptr_d  = '0;
    w_rank      = 0;
    w_idx       = '0;
    w_fc        = 32'(r_freecnt);
    if (!w_ready) begin
      w_list_d[r_icnt]   = BITADDR'(r_icnt);
      w_bitmap_d[r_icnt] = 1'b1;
      w_icnt_d           = idx_t'(fque_wrap_add(32'(r_icnt), 1, NUMADDR));
      w_fc               = w_fc + 1;
    end else begin
      for (int j = 0; j < NUMPOPT; j++) begin
        if (w_gnt[j]) begin
          w_idx                              = idx_t'(fque_wrap_add(32'(r_head), w_rank, NUMADDR));
          w_po_pvld_d[j]                     = 1'b1;
          w_po_ptr_d[j*BITADDR +: BITADDR]   = r_list[w_idx];
          w_bitmap_d[idx_t'(r_list[w_idx])]  = 1'b0;
          w_rank                             = w_rank + 1;
        end
      end
      w_head_d = idx_t'(fque_wrap_add(32'(r_head), 32'(w_ngnt), NUMADDR));
      w_fc     = w_fc - 32'(w_ngnt);
      w_rank   = 0;
      for (int i = 0; i < NUMPUPT; i++) begin
        if (w_acc[i]) begin
          w_idx                          = idx_t'(fque_wrap_add(32'(r_tail), w_rank, NUMADDR));
          w_list_d[w_idx]                = w_pu[i];
          w_bitmap_d[idx_t'(w_pu[i])]    = 1'b1;
          w_rank                         = w_rank + 1;
        end
      end
      w_tail_d = idx_t'(fque_wrap_add(32'(r_tail), w_rank, NUMADDR));
      w_fc     = w_fc + w_rank;
    end
    w_freecnt_d = BITQCNT'(w_fc);
  end

  // Hysteresis: between the two marks the flag holds its value.
  always_comb begin
    w_lowmark_d = r_lowmark;
    if (w_fc < LOWMARK) begin
      w_lowmark_d = 1'b1;
    end else if (w_fc >= HIGHMARK) begin
      w_lowmark_d = 1'b0;
    end
  end

  always_comb begin
    w_err_dup_d = r_err_dup;
    w_err_ovr_d = r_err_ovr;
    if (i_err_clr) begin
      w_err_dup_d = 1'b0;
      w_err_ovr_d = 1'b0;
    end
    if (|w_dup) w_err_dup_d = 1'b1;
    if (|w_ovr) w_err_ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUMADDR; k++) begin
        r_list[k] <= '0;
      end
      r_bitmap  <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_icnt    <= '0;
      r_freecnt <= '0;
      r_lowmark <= 1'b1;
      r_err_dup <= 1'b0;
      r_err_ovr <= 1'b0;
      r_po_pvld <= '0;
      r_po_ptr  <= '0;
    end else begin
      r_list    <= w_list_d;
      r_bitmap  <= w_bitmap_d;
      r_head    <= w_head_d;
      r_tail    <= w_tail_d;
      r_icnt    <= w_icnt_d;
      r_freecnt <= w_freecnt_d;
      r_lowmark <= w_lowmark_d;
      r_err_dup <= w_err_dup_d;
      r_err_ovr <= w_err_ovr_d;
      r_po_pvld <= w_po_pvld_d;
      r_po_ptr  <= w_po_ptr_d;
    end
  end

  assign o_po_pvld = r_po_pvld;
  assign o_po_ptr  = r_po_ptr;
  assign o_freecnt = r_freecnt;
  assign o_lowmark = r_lowmark;
  assign o_err_dup = r_err_dup;
  assign o_err_ovr = r_err_ovr;
  assign o_ready   = w_ready;

endmodule

// File: tb/tb_algo_mrnw_flst.sv
// Bench for algo_mrnw_flst: queue-based reference model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_algo_mrnw_flst;

  localparam int unsigned NPU   = 2;
  localparam int unsigned NPO   = 2;
  localparam int unsigned NA    = 16;
  localparam int unsigned BA    = 5;
  localparam int unsigned BQ    = 6;
  localparam int unsigned LOWM  = 4;
  localparam int unsigned HIGHM = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NPU-1:0]    push = '0;
  logic [NPU*BA-1:0] pu_ptr = '0;
  logic [NPO-1:0]    pop = '0;
  logic              err_clr = 1'b0;
  logic [NPO-1:0]    po_pvld;
  logic [NPO*BA-1:0] po_ptr;
  logic [BQ-1:0]     freecnt;
  logic              lowmark, err_dup, err_ovr, ready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  algo_mrnw_flst #(
    .NUMPUPT (NPU),
    .NUMPOPT (NPO),
    .NUMADDR (NA),
    .BITADDR (BA),
    .BITQCNT (BQ),
    .LOWMARK (LOWM),
    .HIGHMARK(HIGHM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (push),
    .i_pu_ptr (pu_ptr),
    .i_pop    (pop),
    .o_po_pvld(po_pvld),
    .o_po_ptr (po_ptr),
    .o_freecnt(freecnt),
    .o_lowmark(lowmark),
    .o_err_dup(err_dup),
    .o_err_ovr(err_ovr),
    .i_err_clr(err_clr),
    .o_ready  (ready)
  );

  // Reference model: the free list is a plain FIFO of pointer values.
  int fq[$];
  bit mfree [NA];
  int m_init;
  bit m_ready;
  bit m_pvld [NPO];
  int m_ptr  [NPO];
  int m_cnt;
  bit m_low, m_dup, m_ovr;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int ptr_of(input int p);
    return int'(po_ptr[p*BA +: BA]);
  endfunction

  task automatic model_tick();
    int pv, avail, granted;
    bit nd, no, hit;
    int acc_q[$];
    int seen[$];
    if (!rst_n) begin
      fq.delete();
      for (int k = 0; k < NA; k++) mfree[k] = 1'b0;
      m_init = 0; m_ready = 1'b0; m_cnt = 0;
      m_low = 1'b1; m_dup = 1'b0; m_ovr = 1'b0;
      for (int p = 0; p < NPO; p++) begin m_pvld[p] = 1'b0; m_ptr[p] = 0; end
      return;
    end
    nd = 1'b0; no = 1'b0;
    for (int p = 0; p < NPO; p++) begin m_pvld[p] = 1'b0; m_ptr[p] = 0; end
    if (!m_ready) begin
      fq.push_back(m_init);
      mfree[m_init] = 1'b1;
      m_init++;
      if (m_init == NA) m_ready = 1'b1;
    end else begin
      for (int u = 0; u < NPU; u++) begin
        if (push[u]) begin
          pv = int'(pu_ptr[u*BA +: BA]);
          if (pv >= NA) no = 1'b1;
          else begin
            hit = mfree[pv];
            foreach (seen[s]) if (seen[s] == pv) hit = 1'b1;
            if (hit) nd = 1'b1;
            else acc_q.push_back(pv);
            seen.push_back(pv);
          end
        end
      end
      avail = fq.size();
      granted = 0;
      for (int p = 0; p < NPO; p++) begin
        if (pop[p] && granted < avail) begin
          m_ptr[p] = fq.pop_front();
          mfree[m_ptr[p]] = 1'b0;
          m_pvld[p] = 1'b1;
          granted++;
        end
      end
      foreach (acc_q[a]) begin
        fq.push_back(acc_q[a]);
        mfree[acc_q[a]] = 1'b1;
      end
    end
    if (nd) m_dup = 1'b1; else if (err_clr) m_dup = 1'b0;
    if (no) m_ovr = 1'b1; else if (err_clr) m_ovr = 1'b0;
    m_cnt = fq.size();
    if (m_cnt < LOWM) m_low = 1'b1;
    else if (m_cnt >= HIGHM) m_low = 1'b0;
  endtask

  task automatic compare_all();
    check("ready", int'(ready), int'(m_ready));
    check("freecnt", int'(freecnt), m_cnt);
    check("lowmark", int'(lowmark), int'(m_low));
    check("err_dup", int'(err_dup), int'(m_dup));
    check("err_ovr", int'(err_ovr), int'(m_ovr));
    for (int p = 0; p < NPO; p++) begin
      check($sformatf("po_pvld[%0d]", p), int'(po_pvld[p]), int'(m_pvld[p]));
      check($sformatf("po_ptr[%0d]", p), ptr_of(p), m_ptr[p]);
    end
  endtask

  // One clock: advance the model with the inputs the DUT will sample, then compare.
  task automatic step();
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_ready(input string name);
    int cyc;
    cyc = 0;
    while (!ready && cyc < 40) begin
      step();
      cyc++;
    end
    check(name, cyc, 16);
    check({name, "_freecnt"}, int'(freecnt), 16);
    check({name, "_lowmark"}, int'(lowmark), 0);
  endtask

  initial begin
    step();
    step();
    check("rst_freecnt", int'(freecnt), 0);
    check("rst_lowmark", int'(lowmark), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_pvld", int'(po_pvld), 0);

    rst_n = 1'b1;
    wait_ready("init_cycles");

    // Drain everything two at a time.
    pop = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("drain%0d_p0", k), ptr_of(0), 2 * k);
      check($sformatf("drain%0d_p1", k), ptr_of(1), 2 * k + 1);
    end
    pop = '0;
    check("drain_freecnt", int'(freecnt), 0);
    check("drain_lowmark", int'(lowmark), 1);

    // Duplicate free within one cycle, then a repeat of an already free pointer.
    push = 2'b11; pu_ptr = {5'd5, 5'd5};
    step();
    push = '0;
    check("dup_same_cycle_err", int'(err_dup), 1);
    check("dup_same_cycle_cnt", int'(freecnt), 1);
    push = 2'b01; pu_ptr = {5'd0, 5'd5};
    step();
    push = '0;
    check("dup_repeat_cnt", int'(freecnt), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("dup_clr", int'(err_dup), 0);

    // One pointer, two requesters.
    pop = 2'b11;
    step();
    pop = '0;
    check("partial_pvld", int'(po_pvld), 1);
    check("partial_ptr0", ptr_of(0), 5);
    check("partial_ptr1", ptr_of(1), 0);
    check("partial_cnt", int'(freecnt), 0);

    // Pushed pointer is not poppable in the same cycle.
    push = 2'b01; pu_ptr = {5'd0, 5'd3}; pop = 2'b01;
    step();
    push = '0;
    check("bypass_pvld", int'(po_pvld), 0);
    check("bypass_cnt", int'(freecnt), 1);
    step();
    pop = '0;
    check("bypass_next_pvld", int'(po_pvld), 1);
    check("bypass_next_ptr", ptr_of(0), 3);

    // Two accepted pushes keep port order.
    push = 2'b11; pu_ptr = {5'd2, 5'd7};
    step();
    push = '0; pop = 2'b11;
    step();
    pop = '0;
    check("order_p0", ptr_of(0), 7);
    check("order_p1", ptr_of(1), 2);

    // Out-of-range free, and a new error beating a same-cycle clear.
    push = 2'b01; pu_ptr = {5'd0, 5'd16};
    step();
    check("ovr_err", int'(err_ovr), 1);
    check("ovr_cnt", int'(freecnt), 0);
    err_clr = 1'b1;
    step();
    push = '0;
    check("ovr_clr_loses", int'(err_ovr), 1);
    step();
    err_clr = 1'b0;
    check("ovr_clr", int'(err_ovr), 0);

    // Reset in the middle of traffic.
    push = 2'b11; pu_ptr = {5'd6, 5'd4};
    step();
    push = '0; pop = 2'b11;
    rst_n = 1'b0;
    step();
    check("midrst_pvld", int'(po_pvld), 0);
    check("midrst_cnt", int'(freecnt), 0);
    check("midrst_low", int'(lowmark), 1);
    check("midrst_ready", int'(ready), 0);
    rst_n = 1'b1;
    wait_ready("reinit_cycles");
    step();
    pop = '0;
    check("reinit_p0", ptr_of(0), 0);
    check("reinit_p1", ptr_of(1), 1);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/algo_mrnw_flst.md
ALGO_MRNW_FLST -- requirements
Module: algo_mrnw_flst

Interface
REQ-001 SHALL have parameters: NUMPUPT, default 2, number of push (free) ports; NUMPOPT, default 2, number of pop (allocate) ports; NUMADDR, default 16, number of managed pointers; BITADDR, default 4, pointer width; BITQCNT, default BITADDR+1, count width; LOWMARK, default 4, low-water assert threshold; HIGHMARK, default 8, low-water deassert threshold.
REQ-002 SHALL have ports, with clock and reset first:
clk  in  1  the only clock
rst_n  in  1  asynchronous, active-low reset
push  in  NUMPUPT  per-port free request
pu_ptr  in  NUMPUPT*BITADDR  pointer returned, port i at bits [i*BITADDR +: BITADDR]
pop  in  NUMPOPT  per-port allocate request
po_pvld  out  NUMPOPT  allocated pointer valid
po_ptr  out  NUMPOPT*BITADDR  allocated pointer, same packing as pu_ptr
freecnt  out  BITQCNT  free pointers held
lowmark  out  1  low-water flag
err_dup  out  1  sticky: duplicate free seen
err_ovr  out  1  sticky: push of out-of-range pointer
err_clr  in  1  clears both sticky errors
ready  out  1  initialisation complete

Function
REQ-003 SHALL store free pointers in a flop-based circular list of NUMADDR entries with head and tail indices wrapping explicitly at NUMADDR, which need not be a power of two.
REQ-004 SHALL, after reset, write pointer k into entry k, one entry per cycle for k = 0..NUMADDR-1, holding ready=0; ready SHALL rise the cycle after the last write, with freecnt = NUMADDR.
REQ-005 SHALL ignore push and pop while ready=0.
REQ-006 SHALL, on a pop cycle, grant pops to set bits of pop in ascending port index, up to the freecnt value sampled at the start of the cycle.
REQ-007 SHALL return granted pointers one cycle after the pop cycle, with po_pvld=1 on granted ports and po_pvld=0 on ungranted or idle ports; po_ptr of a port with po_pvld=0 SHALL be 0.
REQ-008 SHALL apply no retry to ungranted pops; the requester reissues them.
REQ-009 SHALL keep a NUMADDR-bit free bitmap, setting the bit on push and clearing it on grant.
REQ-010 SHALL drop a push whose pointer bit is already set, or which matches a lower-indexed push in the same cycle, and set err_dup.
REQ-011 SHALL drop a push with pu_ptr >= NUMADDR and set err_ovr.
REQ-012 SHALL append accepted pushes at the tail in ascending port index.
REQ-013 SHALL keep pointers pushed in cycle N unavailable to pops until cycle N+1.
REQ-014 SHALL update freecnt by accepted pushes minus granted pops once per cycle, with no underflow or overflow possible.
REQ-015 SHALL register lowmark: set when the next freecnt < LOWMARK, cleared when the next freecnt >= HIGHMARK, otherwise held.
REQ-016 SHALL clear the sticky errors on err_clr; a same-cycle new error SHALL win.

Reset
REQ-017 SHALL, while rst_n=0, hold po_pvld=0, po_ptr=0, freecnt=0, lowmark=1, err_dup=0, err_ovr=0 and ready=0, and clear head, tail, bitmap and the init counter.
REQ-018 SHALL restart initialisation from entry 0 when rst_n is asserted mid-operation, discarding all outstanding pops.

Structure
REQ-019 SHALL take from the shared fque package the pointer/count typedefs and the wrap-increment function.
REQ-020 SHALL place the ascending-priority grant of N requests against an available count in one sub-module, algo_mrnw_flst_grant.

Verification
REQ-021 Reset release with NUMADDR=16 -> ready=0 for 16 cycles, then ready=1, freecnt=16, lowmark=0.
REQ-022 pop=2'b11 on cycles 1..8 -> pointers 0..15 returned in order, port 0 takes the even pointers, freecnt=0, lowmark=1 after freecnt falls below 4.
REQ-023 freecnt=1 with pop=2'b11 -> port 0 valid, port 1 po_pvld=0, freecnt=0.
REQ-024 Push ptr 5 on both ports in one cycle while 5 is allocated -> one accepted, err_dup=1; a later push of ptr 5 again -> dropped; err_clr -> err_dup=0.
REQ-025 freecnt=0, push ptr 3 and pop in the same cycle -> no grant; 3 is granted the next cycle.
REQ-026 Push ptr 16 -> err_ovr=1 and freecnt unchanged; rst_n pulse mid-stream -> outputs at reset values and a full re-initialisation.
